cci_mpf_prim_multi_write_gen: RTL and testbench
===============================================

Name: cci_mpf_prim_multi_write_gen

Overview:
- Transmitter for multi-line CCI-MPF write packets.
- Accepts one write request header plus a stream of cache-line data beats.
- Emits the legal c1Tx beat sequence for that request: SOP on beat 0 only, constant cl_len, beat-indexed low address bits, and flow control from c1TxAlmFull.
- Sits between an AFU-side write engine and the MPF c1Tx pipeline. Its output passes a multi-write beat tracker with no assertion failures.

Parameters:
- MAX_CL_LEN, 3, largest accepted cl_len encoding (0=1 line, 1=2 lines, 3=4 lines); 2 is never legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request header offered
- req_hdr  in  t_cci_mpf_c1_ReqMemHdr  write header; base.address, base.cl_len, mdata used
- req_ready  out  1  header accepted this cycle when req_valid && req_ready
- data_valid  in  1  data beat offered
- data  in  t_cci_clData  beat payload
- data_ready  out  1  data beat consumed this cycle
- c1TxAlmFull  in  1  downstream almost-full
- c1Tx  out  t_if_cci_mpf_c1_Tx  registered write beat channel
- busy  out  1  packet in progress (state BURST)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset values: c1Tx.valid=0, c1Tx header cleared, busy=0, state IDLE, beat counter 0, req_ready=0 during reset.
- States and acceptance:
  - IDLE: req_ready=1 when !c1TxAlmFull. On accept, latch the header.
  - Latched address = req_hdr address with the low 2 bits ANDed with ~cl_len, so the start is aligned to the packet size.
  - Then go to BURST with beat=0.
- BURST:
  - data_ready = !c1TxAlmFull.
  - Each data_valid && data_ready registers one write beat onto c1Tx the next cycle (latency 1).
  - Beat header fields:
    - sop = (beat==0)
    - cl_len = latched cl_len
    - address = latched base, low 2 bits ORed with beat
    - mdata = latched mdata
  - When beat==cl_len, the beat is the last one: return to IDLE and reset beat to 0. Otherwise beat+1.
  - Beat counter is t_cci_clNum width and never wraps past cl_len.
- c1Tx.valid is high for exactly one cycle per consumed data beat and low otherwise. No beat is issued while c1TxAlmFull is sampled high.
- No overlap: req_ready=0 in BURST. A new request is accepted no earlier than the cycle after the last beat is consumed.
- Single-line (cl_len=0): accept, then the first data beat both starts and ends the packet. Back-to-back single-line writes sustain 1 beat per 2 cycles.
- Illegal cl_len:
  - cl_len==2 is treated as cl_len=3.
  - cl_len > MAX_CL_LEN is clamped to MAX_CL_LEN.
  - Output is always a legal packet.
- c1TxAlmFull asserted mid-packet: the packet pauses and resumes with the same beat index. SOP is not reissued.
- Reset mid-packet: the packet is abandoned, state returns to IDLE, and no further beats are issued. Downstream sees a truncated packet; system reset covers that.
- Data beats presented in IDLE are not consumed (data_ready=0).

Optional Feature:
- Macro: CCI_MPF_PRIM_MULTI_WRITE_ERR_EN.
- When defined:
  - Adds output err (1 bit, sticky, cleared only by reset).
  - err sets on the accept cycle of any request with unaligned base address bits, cl_len==2, or cl_len > MAX_CL_LEN.
  - A simulation-only $warning reports the offending address and cl_len.
- When undefined: the err port is absent and correction is silent. Datapath behaviour is identical either way.

Decomposition:
- Shared package cci_mpf_prim_pkg:
  - state enum t_multi_write_gen_state {IDLE, BURST}
  - function cl_len legalisation (clamp/2→3)
  - function address alignment mask
- Header construction uses existing cci_mpf_c1_genReqHdr-style helpers.
- Natural sub-module: cci_mpf_prim_multi_write_beat_ctr. It holds the beat counter, last-beat detect and SOP generation, and is reusable by a read-response beat generator.

Test Plan:
- 4-line packet: req addr=0x1000, cl_len=3, 4 data beats, AlmFull=0 -> c1Tx beats at addrs 0x1000–0x1003, sop=1,0,0,0, cl_len=3 each, busy falls after beat 3, req_ready back next cycle.
- Misaligned 2-line: req addr=0x2003, cl_len=1 -> beats at 0x2002, 0x2003. With ERR_EN, err=1 and stays 1.
- cl_len=2 request at addr 0x30 -> emitted as 4 beats 0x30–0x33, cl_len=3 on every beat.
- AlmFull stall: 4-line packet, AlmFull high for 5 cycles after beat 1 -> no c1Tx.valid during stall, data_ready=0, beat 2 resumes with sop=0 at addr base+2.
- Back-to-back: three cl_len=0 requests with data always valid -> three beats, each sop=1, one cycle gap minimum, no request accepted while busy=1.
- Reset mid-packet: reset after beat 1 of a 4-line packet -> c1Tx.valid=0 and busy=0 the next cycle, state IDLE. A new request is then accepted and starts with sop=1.

Source files
------------

// File: rtl/cci_mpf_prim_pkg.sv
// Shared types and helpers for the MPF multi-line write primitives.
package cci_mpf_prim_pkg;

  typedef logic [41:0]  t_cci_clAddr;
  typedef logic [1:0]   t_cci_clLen;
  typedef logic [1:0]   t_cci_clNum;
  typedef logic [15:0]  t_cci_mdata;
  typedef logic [511:0] t_cci_clData;

  typedef struct packed {
    t_cci_clAddr address;
    t_cci_clLen  cl_len;
    logic        sop;
  } t_cci_mpf_c1_ReqMemHdrBase;

  typedef struct packed {
    t_cci_mpf_c1_ReqMemHdrBase base;
    t_cci_mdata                mdata;
  } t_cci_mpf_c1_ReqMemHdr;

  typedef struct packed {
    t_cci_mpf_c1_ReqMemHdr hdr;
    t_cci_clData           data;
    logic                  valid;
  } t_if_cci_mpf_c1_Tx;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST
  } t_multi_write_gen_state;

  // 2 is not a legal length encoding; round it up to a 4-line packet first.
  function automatic t_cci_clLen legal_cl_len(t_cci_clLen len, t_cci_clLen max_len);
    t_cci_clLen l;
    l = (len == 2'd2) ? 2'd3 : len;
    if (l > max_len) l = max_len;
    return l;
  endfunction

  function automatic t_cci_clAddr align_mask(t_cci_clLen len);
    return ~t_cci_clAddr'(len);
  endfunction

  function automatic t_cci_mpf_c1_ReqMemHdr cci_mpf_c1_genReqHdr(
    t_cci_clAddr address,
    t_cci_clLen  cl_len,
    logic        sop,
    t_cci_mdata  mdata
  );
    t_cci_mpf_c1_ReqMemHdr h;
    h              = '0;
    h.base.address = address;
    h.base.cl_len  = cl_len;
    h.base.sop     = sop;
    h.mdata        = mdata;
    return h;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_multi_write_beat_ctr.sv
// Beat index, last-beat detect and SOP for one multi-line packet.
module cci_mpf_prim_multi_write_beat_ctr
  import cci_mpf_prim_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       advance,
  input  t_cci_clLen cl_len,
  output t_cci_clNum beat,
  output logic       last,
  output logic       sop
);

  assign last = (beat == t_cci_clNum'(cl_len));
  assign sop  = (beat == '0);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      beat <= '0;
    end else if (advance) begin
      beat <= last ? '0 : t_cci_clNum'(beat + 2'd1);
    end
  end

endmodule

// File: rtl/cci_mpf_prim_multi_write_gen.sv
// Multi-line c1Tx write packet generator: one header in, cl_len+1 beats out.
// Optional sticky illegal-request flag: CCI_MPF_PRIM_MULTI_WRITE_ERR_EN.
module cci_mpf_prim_multi_write_gen
  import cci_mpf_prim_pkg::*;
#(
  parameter int MAX_CL_LEN = 3
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  t_cci_mpf_c1_ReqMemHdr req_hdr,
  output logic                  req_ready,
  input  logic                  data_valid,
  input  t_cci_clData           data,
  output logic                  data_ready,
  input  logic                  c1TxAlmFull,
  output t_if_cci_mpf_c1_Tx     c1Tx,
  output logic                  busy
`ifdef CCI_MPF_PRIM_MULTI_WRITE_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam t_cci_clLen MAX_LEN = t_cci_clLen'(MAX_CL_LEN);

  t_multi_write_gen_state state;
  t_cci_clAddr            lat_addr;
  t_cci_clLen             lat_len;
  t_cci_mdata             lat_mdata;
  t_cci_clLen             req_len;
  t_cci_clNum             beat;
  logic                   beat_last, beat_sop;
  logic                   accept, consume;
  logic                   tx_valid;
  t_cci_mpf_c1_ReqMemHdr  tx_hdr;
  t_cci_clData            tx_data;
  t_cci_clAddr            beat_addr;
  logic                   unused_sop;

  assign unused_sop = req_hdr.base.sop;
  assign req_len    = legal_cl_len(req_hdr.base.cl_len, MAX_LEN);

  assign req_ready  = !reset && (state == IDLE)  && !c1TxAlmFull;
  assign data_ready = !reset && (state == BURST) && !c1TxAlmFull;
  assign accept     = req_valid  && req_ready;
  assign consume    = data_valid && data_ready;
  assign busy       = (state == BURST);

  cci_mpf_prim_multi_write_beat_ctr u_beat_ctr (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .advance (consume),
    .cl_len  (lat_len),
    .beat    (beat),
    .last    (beat_last),
    .sop     (beat_sop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state <= BURST;
        BURST:   if (consume && beat_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_len   <= '0;
      lat_mdata <= '0;
    end else if (accept) begin
      lat_addr  <= req_hdr.base.address & align_mask(req_len);
      lat_len   <= req_len;
      lat_mdata <= req_hdr.mdata;
    end
  end

  // Base is aligned, so OR-ing the beat index is the same as adding it.
  assign beat_addr = {lat_addr[41:2], lat_addr[1:0] | beat};

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_hdr   <= '0;
      tx_data  <= '0;
    end else begin
      tx_valid <= consume;
      if (consume) begin
        tx_hdr  <= cci_mpf_c1_genReqHdr(beat_addr, lat_len, beat_sop, lat_mdata);
        tx_data <= data;
      end
    end
  end

  assign c1Tx = '{hdr: tx_hdr, data: tx_data, valid: tx_valid};

`ifdef CCI_MPF_PRIM_MULTI_WRITE_ERR_EN
  logic bad_req;
  assign bad_req = ((req_hdr.base.address[1:0] & req_len) != 2'b00) ||
                   (req_hdr.base.cl_len == 2'd2) ||
                   (req_hdr.base.cl_len > MAX_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && bad_req) begin
      err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && accept && bad_req)
      $warning("multi_write_gen: illegal request addr=0x%0h cl_len=%0d",
               req_hdr.base.address, req_hdr.base.cl_len);
  end
`endif
`endif

endmodule

// File: tb/tb_cci_mpf_prim_multi_write_gen.sv
// Scoreboard bench for cci_mpf_prim_multi_write_gen: directed plan cases, then random traffic.
module tb_cci_mpf_prim_multi_write_gen;
  import cci_mpf_prim_pkg::*;

  localparam int MAXL = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  req_valid = 1'b0;
  t_cci_mpf_c1_ReqMemHdr req_hdr = '0;
  logic                  req_ready;
  logic                  data_valid = 1'b0;
  t_cci_clData           data = '0;
  logic                  data_ready;
  logic                  alm = 1'b0;
  t_if_cci_mpf_c1_Tx     c1Tx;
  logic                  busy;
`ifdef CCI_MPF_PRIM_MULTI_WRITE_ERR_EN
  logic                  err;
`endif

  cci_mpf_prim_multi_write_gen #(.MAX_CL_LEN(MAXL)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_hdr     (req_hdr),
    .req_ready   (req_ready),
    .data_valid  (data_valid),
    .data        (data),
    .data_ready  (data_ready),
    .c1TxAlmFull (alm),
    .c1Tx        (c1Tx),
    .busy        (busy)
`ifdef CCI_MPF_PRIM_MULTI_WRITE_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [41:0] addr;
    bit          sop;
    logic [1:0]  len;
    logic [15:0] mdata;
    t_cci_clData d;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_fail = 0;
  bit   model_busy = 0, exp_vld = 0, mon_on = 0;
  bit   alm_force = 0, alm_rand = 0, dv_always = 0, exp_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Handshakes are judged mid-cycle, they take effect on the following edge.
  task automatic step(output bit rf, output bit df);
    @(negedge clk);
    rf = req_valid && req_ready;
    df = data_valid && data_ready;
    @(posedge clk);
    #1;
    exp_vld = df;
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    alm = alm_force ? 1'b1 : (alm_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      chk("c1tx_valid", 64'(c1Tx.valid), 64'(exp_vld));
      if (c1Tx.valid === 1'b1) begin
        if (q.size() == 0) fail_now("unexpected_beat");
        else begin
          e = q.pop_front();
          chk("beat_addr",   64'(c1Tx.hdr.base.address), 64'(e.addr));
          chk("beat_sop",    64'(c1Tx.hdr.base.sop),     64'(e.sop));
          chk("beat_cl_len", 64'(c1Tx.hdr.base.cl_len),  64'(e.len));
          chk("beat_mdata",  64'(c1Tx.hdr.mdata),        64'(e.mdata));
          chk("beat_data_lo", c1Tx.data[63:0],    e.d[63:0]);
          chk("beat_data_hi", c1Tx.data[511:448], e.d[511:448]);
        end
      end
      chk("busy",       64'(busy),       64'(model_busy));
      chk("req_ready",  64'(req_ready),  64'(!reset && !model_busy && !alm));
      chk("data_ready", 64'(data_ready), 64'(!reset && model_busy && !alm));
`ifdef CCI_MPF_PRIM_MULTI_WRITE_ERR_EN
      chk("err", 64'(err), 64'(exp_err));
`endif
    end
  end

  task automatic send_pkt(input logic [41:0] addr, input int cl, input int stall_at, input int abort_at);
    int          len, nb, cyc;
    logic [41:0] base;
    logic [15:0] md;
    bit          bad, rf, df;
    exp_t        e;
    t_cci_clData d;
    len  = (cl == 2) ? 3 : cl;
    if (len > MAXL) len = MAXL;
    nb   = len + 1;
    base = addr - (addr % 42'(nb));
    bad  = ((addr % 42'(nb)) != 0) || (cl == 2) || (cl > MAXL);
    md   = 16'($urandom);

    req_hdr               = '0;
    req_hdr.base.address  = addr;
    req_hdr.base.cl_len   = 2'(cl);
    req_hdr.base.sop      = 1'($urandom);
    req_hdr.mdata         = md;
    req_valid             = 1'b1;
    for (int k = 0; k < 16; k++) data[k*32 +: 32] = $urandom;
    data_valid = 1'($urandom_range(0, 1));
    cyc = 0;
    do begin step(rf, df); cyc++; end while (!rf && cyc < 200);
    if (!rf) begin fail_now("req_accept_timeout"); req_valid = 1'b0; return; end
    model_busy = 1;
    if (bad) exp_err = 1;

    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
      data = d;
      if (i == abort_at) begin
        data_valid = 1'b0;
        req_valid  = 1'b0;
        reset      = 1'b1;
        step(rf, df);
        reset      = 1'b0;
        model_busy = 0;
        exp_err    = 0;
        return;
      end
      cyc = 0;
      do begin
        data_valid = dv_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        req_valid  = 1'($urandom_range(0, 1));
        req_hdr.base.address = {10'($urandom), $urandom};
        step(rf, df);
        cyc++;
      end while (!df && cyc < 200);
      if (!df) begin fail_now("data_accept_timeout"); data_valid = 1'b0; req_valid = 1'b0; return; end
      e.addr = base + 42'(i); e.sop = (i == 0); e.len = 2'(len); e.mdata = md; e.d = d;
      q.push_back(e);
      if (i == len) begin
        model_busy = 0;
        req_valid  = 1'b0;
      end
      if (i == stall_at) begin
        alm_force  = 1;
        data_valid = 1'b1;
        repeat (5) begin
          step(rf, df);
          if (df) fail_now("beat_during_almfull");
        end
        alm_force = 0;
      end
    end
    data_valid = 1'b0;
    req_valid  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rf, df;
    int cl;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_valid",      64'(c1Tx.valid), 64'd0);
    chk("reset_busy",       64'(busy),       64'd0);
    chk("reset_req_ready",  64'(req_ready),  64'd0);
    chk("reset_data_ready", 64'(data_ready), 64'd0);
    chk("reset_hdr",        64'(c1Tx.hdr.base.address), 64'd0);
    mon_on = 1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    send_pkt(42'h1000, 3, -1, -1);
    send_pkt(42'h2003, 1, -1, -1);
    send_pkt(42'h30,   2, -1, -1);
    send_pkt(42'h4000, 3,  1, -1);
    dv_always = 1;
    for (int k = 0; k < 3; k++) send_pkt(42'h5000 + 42'(k), 0, -1, -1);
    send_pkt(42'h6000, 3, -1, 2);
    send_pkt(42'h7000, 3, -1, -1);
    dv_always = 0;

    alm_rand = 1;
    repeat (150) begin
      cl = int'($urandom_range(0, 3));
      send_pkt({10'($urandom), $urandom}, cl, -1,
               ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1);
    end
    alm_rand = 0;
    repeat (4) step(rf, df);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
